// File: rtl/keypad_events.sv
// Keypad event generator: per-key sample-strobed debounce, pending-event
// arbitration (lowest index first) and a first-word fall-through event queue
// with a sticky overflow flag for events lost while still pending.
module keypad_events #(
  parameter int NKEYS        = 16,
  parameter int IDX_W        = 4,
  parameter int DEBOUNCE     = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int RELEASE_ONLY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic [NKEYS-1:0] keypad_matrix,
  input  logic             ev_ready,
  input  logic             clr_overflow,
  output logic             ev_valid,
  output logic [IDX_W-1:0] ev_index,
  output logic             ev_press,
  output logic [NKEYS-1:0] keys_stable,
  output logic             any_pressed,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IDX_W + 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

  logic [3:0]       cnt      [NKEYS];
  logic [3:0]       cnt_next [NKEYS];
  logic [NKEYS-1:0] toggle;
  logic [NKEYS-1:0] stable_next;
  logic [NKEYS-1:0] set_mask;
  logic [NKEYS-1:0] pend;
  logic [NKEYS-1:0] grant_mask;
  logic [NKEYS-1:0] eff_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W:0]   occ;
  logic [ENT_W-1:0] head;
  logic             full;
  logic             push;
  logic             pop;
  logic             ovf_cond;

  // Debounce next-state: count disagreeing samples, toggle on reaching DEBOUNCE
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_next[i] = cnt[i];
      if (sample) begin
        if (keypad_matrix[i] != keys_stable[i]) begin
          if (cnt[i] + 4'd1 == 4'(DEBOUNCE)) begin
            toggle[i]   = 1'b1;
            cnt_next[i] = '0;
          end else begin
            cnt_next[i] = cnt[i] + 4'd1;
          end
        end else begin
          cnt_next[i] = '0;
        end
      end
    end
  end

  assign stable_next = keys_stable ^ toggle;
  // Press toggles are not queued in release-only mode
  assign set_mask    = (RELEASE_ONLY != 0) ? (toggle & ~stable_next) : toggle;
  assign any_pressed = |keys_stable;

  // Fixed-priority arbiter: lowest-index pending key wins
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_mask = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    if (grant_vld) grant_mask[grant_idx] = 1'b1;
  end

  assign full      = (occ == FULL_OCC);
  assign pop       = ev_valid & ev_ready;
  assign push      = grant_vld & (~full | pop);
  assign eff_grant = push ? grant_mask : '0;
  // A new toggle on a key whose previous event never left pending is a lost edge
  assign ovf_cond  = |(toggle & pend & ~eff_grant);

  assign ev_valid = (occ != '0);
  // When empty, show the most recently popped entry so outputs hold their value
  assign last_ptr = rd_ptr - PTR_W'(1);
  assign head     = ev_valid ? mem[rd_ptr] : mem[last_ptr];
  assign ev_index = head[ENT_W-1:1];
  assign ev_press = head[0];

  // Debounce counters and stable key state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
      keys_stable <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) cnt[i] <= cnt_next[i];
      keys_stable <= stable_next;
    end
  end

  // Pending bits and sticky overflow; a fresh overflow beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~eff_grant) | set_mask;
      if (ovf_cond)          overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Event queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {grant_idx, keys_stable[grant_idx]};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W + 1)'(1);
        2'b01:   occ <= occ - (PTR_W + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_events.sv
// Directed testbench for keypad_events: a default-configuration instance and a
// release-only instance share all inputs.
module tb_keypad_events;

  localparam int NK = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample = 1'b0;
  logic          ev_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [NK-1:0] keypad_matrix = '0;

  logic          ev_valid, ev_press, any_pressed, overflow;
  logic [3:0]    ev_index;
  logic [NK-1:0] keys_stable;

  logic          ro_valid, ro_press, ro_any, ro_overflow;
  logic [3:0]    ro_index;
  logic [NK-1:0] ro_stable;

  int n_checks = 0;
  int n_fail = 0;

  keypad_events #(.NKEYS(NK), .IDX_W(4), .DEBOUNCE(3), .FIFO_DEPTH(4), .RELEASE_ONLY(0)) dut (
    .clk(clk), .reset(reset), .sample(sample), .keypad_matrix(keypad_matrix),
    .ev_ready(ev_ready), .clr_overflow(clr_overflow), .ev_valid(ev_valid),
    .ev_index(ev_index), .ev_press(ev_press), .keys_stable(keys_stable),
    .any_pressed(any_pressed), .overflow(overflow)
  );

  keypad_events #(.NKEYS(NK), .IDX_W(4), .DEBOUNCE(3), .FIFO_DEPTH(4), .RELEASE_ONLY(1)) dut_ro (
    .clk(clk), .reset(reset), .sample(sample), .keypad_matrix(keypad_matrix),
    .ev_ready(ev_ready), .clr_overflow(clr_overflow), .ev_valid(ro_valid),
    .ev_index(ro_index), .ev_press(ro_press), .keys_stable(ro_stable),
    .any_pressed(ro_any), .overflow(ro_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Three samples one idle cycle apart; returns in the cycle after the third
  task automatic settle3();
    pulse(); idle(1); pulse(); idle(1); pulse();
  endtask

  task automatic test_reset();
    keypad_matrix = '1; sample = 1'b1; ev_ready = 1'b1; clr_overflow = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0; sample = 1'b0; ev_ready = 1'b0; keypad_matrix = '0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
    n_checks++; if (ev_index !== 4'd0) begin n_fail++; $display("FAIL rst_index: got %0d want 0", ev_index); end
    n_checks++; if (ev_press !== 1'b0) begin n_fail++; $display("FAIL rst_press: got %b want 0", ev_press); end
    n_checks++; if (any_pressed !== 1'b0) begin n_fail++; $display("FAIL rst_any: got %b want 0", any_pressed); end
    n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL rst_stable: got %h want 0000", keys_stable); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_checks++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ro_valid: got %b want 0", ro_valid); end
    tick();
    n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL rst_stable2: got %h want 0000", keys_stable); end
  endtask

  task automatic test_debounce();
    apply_reset();
    keypad_matrix = 16'h0020;
    pulse();
    n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL db_s1: got %h want 0000", keys_stable); end
    idle(9); pulse();
    n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL db_s2: got %h want 0000", keys_stable); end
    idle(9); pulse();
    n_checks++; if (keys_stable !== 16'h0020) begin n_fail++; $display("FAIL db_s3: got %h want 0020", keys_stable); end
    n_checks++; if (any_pressed !== 1'b1) begin n_fail++; $display("FAIL db_any: got %b want 1", any_pressed); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL db_early_valid: got %b want 0", ev_valid); end
    tick();
    n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b1, 4'd5, 1'b1})
      begin n_fail++; $display("FAIL db_event: got v=%b i=%0d p=%b want v=1 i=5 p=1", ev_valid, ev_index, ev_press); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b0, 4'd5, 1'b1})
      begin n_fail++; $display("FAIL db_hold: got v=%b i=%0d p=%b want v=0 i=5 p=1", ev_valid, ev_index, ev_press); end
    idle(10);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL db_single: got %b want 0", ev_valid); end
    keypad_matrix = '0;
  endtask

  task automatic test_bounce();
    bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      keypad_matrix[2] = pat[s];
      pulse();
      if (s == 4) begin
        n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL bn_s5: got %h want 0000", keys_stable); end
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL bn_s5_valid: got %b want 0", ev_valid); end
      end
      if (s == 5) begin
        n_checks++; if (keys_stable !== 16'h0004) begin n_fail++; $display("FAIL bn_s6: got %h want 0004", keys_stable); end
      end
      if (s < 5) idle(9);
    end
    tick();
    n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b1, 4'd2, 1'b1})
      begin n_fail++; $display("FAIL bn_event: got v=%b i=%0d p=%b want v=1 i=2 p=1", ev_valid, ev_index, ev_press); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    idle(5);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL bn_single: got %b want 0", ev_valid); end
    keypad_matrix = '0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    ev_ready = 1'b1;
    keypad_matrix = 16'h0208;
    settle3();
    n_checks++; if (keys_stable !== 16'h0208) begin n_fail++; $display("FAIL sim_stable: got %h want 0208", keys_stable); end
    tick();
    n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b1, 4'd3, 1'b1})
      begin n_fail++; $display("FAIL sim_first: got v=%b i=%0d p=%b want v=1 i=3 p=1", ev_valid, ev_index, ev_press); end
    tick();
    n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b1, 4'd9, 1'b1})
      begin n_fail++; $display("FAIL sim_second: got v=%b i=%0d p=%b want v=1 i=9 p=1", ev_valid, ev_index, ev_press); end
    tick();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL sim_empty: got %b want 0", ev_valid); end
    ev_ready = 1'b0;
    keypad_matrix = '0;
  endtask

  task automatic test_full_fifo();
    int exp_idx [6] = '{1, 4, 6, 8, 10, 12};
    apply_reset();
    ev_ready = 1'b0;
    keypad_matrix = 16'h1552;
    settle3();
    idle(8);
    n_checks++; if ({ev_valid, ev_index} !== {1'b1, 4'd1})
      begin n_fail++; $display("FAIL full_head: got v=%b i=%0d want v=1 i=1", ev_valid, ev_index); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %b want 0", overflow); end
    ev_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b1, 4'(exp_idx[k]), 1'b1})
        begin n_fail++; $display("FAIL full_drain%0d: got v=%b i=%0d p=%b want v=1 i=%0d p=1", k, ev_valid, ev_index, ev_press, exp_idx[k]); end
      tick();
    end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", ev_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_end: got %b want 0", overflow); end
    ev_ready = 1'b0;
    keypad_matrix = '0;
  endtask

  task automatic test_lost_edge();
    int  exp_idx [5] = '{0, 1, 2, 3, 7};
    bit  exp_prs [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    ev_ready = 1'b0;
    keypad_matrix = 16'h008F;
    settle3();
    idle(6);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL lost_pre_ovf: got %b want 0", overflow); end
    keypad_matrix = 16'h000F;
    settle3();
    n_checks++; if (keys_stable !== 16'h000F) begin n_fail++; $display("FAIL lost_stable: got %h want 000f", keys_stable); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL lost_ovf: got %b want 1", overflow); end
    idle(2);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL lost_sticky: got %b want 1", overflow); end
    ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if ({ev_valid, ev_index, ev_press} !== {1'b1, 4'(exp_idx[k]), exp_prs[k]})
        begin n_fail++; $display("FAIL lost_drain%0d: got v=%b i=%0d p=%b want v=1 i=%0d p=%b", k, ev_valid, ev_index, ev_press, exp_idx[k], exp_prs[k]); end
      tick();
    end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL lost_empty: got %b want 0", ev_valid); end
    ev_ready = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL lost_ovf_hold: got %b want 1", overflow); end
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL lost_clr: got %b want 0", overflow); end
    keypad_matrix = '0;
  endtask

  task automatic test_reset_queued();
    apply_reset();
    keypad_matrix = 16'h0020;
    settle3();
    tick();
    n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL rq_queued: got %b want 1", ev_valid); end
    keypad_matrix = 16'h0060;
    pulse(); idle(1); pulse();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rq_valid: got %b want 0", ev_valid); end
    n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL rq_stable: got %h want 0000", keys_stable); end
    pulse();
    n_checks++; if (keys_stable !== 16'h0000) begin n_fail++; $display("FAIL rq_cnt_cleared: got %h want 0000", keys_stable); end
    idle(5);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rq_no_event: got %b want 0", ev_valid); end
    keypad_matrix = '0;
  endtask

  task automatic test_release_only();
    apply_reset();
    keypad_matrix = 16'h0001;
    settle3();
    n_checks++; if (ro_stable !== 16'h0001) begin n_fail++; $display("FAIL ro_press_stable: got %h want 0001", ro_stable); end
    idle(5);
    n_checks++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL ro_no_press_ev: got %b want 0", ro_valid); end
    keypad_matrix = 16'h0000;
    settle3();
    n_checks++; if (ro_stable !== 16'h0000) begin n_fail++; $display("FAIL ro_rel_stable: got %h want 0000", ro_stable); end
    tick();
    n_checks++; if ({ro_valid, ro_index, ro_press} !== {1'b1, 4'd0, 1'b0})
      begin n_fail++; $display("FAIL ro_release_ev: got v=%b i=%0d p=%b want v=1 i=0 p=0", ro_valid, ro_index, ro_press); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    n_checks++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL ro_single: got %b want 0", ro_valid); end
    keypad_matrix = 16'h0002;
    pulse(); idle(1); pulse();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (ro_stable !== 16'h0000) begin n_fail++; $display("FAIL ro_rst_stable: got %h want 0000", ro_stable); end
    pulse();
    n_checks++; if (ro_stable !== 16'h0000) begin n_fail++; $display("FAIL ro_rst_cnt: got %h want 0000", ro_stable); end
    idle(5);
    n_checks++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL ro_rst_no_event: got %b want 0", ro_valid); end
    keypad_matrix = '0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_bounce();
    test_simultaneous();
    test_full_fifo();
    test_lost_edge();
    test_reset_queued();
    test_release_only();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
